// File: rtl/bike_2_keygen_top_if.sv
// rtl/bike_2_keygen_top_if.sv - control, PRNG handshake and serial key output bundle
interface bike_2_keygen_top_if;
  logic        start;
  logic        rng_valid;
  logic [63:0] rng_in;
  logic [1:0]  rng_start;
  logic        h0_out;
  logic        h1_out;
  logic        f_out;
  logic        out_valid;
  logic        done;

  modport master (
    output start, rng_valid, rng_in,
    input  rng_start, h0_out, h1_out, f_out, out_valid, done
  );

  modport slave (
    input  start, rng_valid, rng_in,
    output rng_start, h0_out, h1_out, f_out, out_valid, done
  );
endinterface

// File: rtl/bike_2_keygen_top.sv
// rtl/bike_2_keygen_top.sv - BIKE-2 keygen: sparse h0/h1 sampling, h0 inversion, f = h1*h0^-1, serial output
module bike_2_keygen_top #(
  parameter int R  = 101,
  parameter int D  = 15,
  parameter int LR = 7
) (
  input  logic               clk,
  input  logic               rst_b,
  bike_2_keygen_top_if.slave bus
);
  localparam int             WW  = $clog2(D + 1);
  localparam logic [R-1:0]   ONE = {{(R-1){1'b0}}, 1'b1};
  localparam logic [LR:0]    R_W = (LR+1)'(R);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_SQ, S_INV, S_MUL, S_OUT, S_DONE
  } state_t;

  state_t          r_state;
  logic [R-1:0]    r_h0, r_h1, r_a, r_s;
  logic [R-1:0]    r_rot, r_mb, r_acc;
  logic [WW-1:0]   r_w;
  logic            r_sel, r_seed;
  logic [LR-1:0]   r_cnt, r_iter;
  logic [1:0]      r_rng_start;
  logic            r_h0_out, r_h1_out, r_f_out, r_out_valid, r_done;

  logic [LR-1:0]   w_p;
  logic [R-1:0]    w_onehot, w_cur, w_sq, w_rot_nx, w_mul_res;
  logic            w_accept, w_full;
  logic            w_unused_rng;

  assign w_p          = bus.rng_in[LR-1:0];
  assign w_unused_rng = &{1'b0, bus.rng_in[63:LR]};
  // A position >= R shifts the one-hot out entirely, so the range test only guards acceptance.
  assign w_onehot     = ONE << w_p;
  assign w_cur        = r_sel ? r_h1 : r_h0;
  assign w_accept     = ({1'b0, w_p} < R_W) && ((w_cur & w_onehot) == '0);
  assign w_full       = (r_w == WW'(D - 1));
  assign w_rot_nx     = {r_rot[R-2:0], r_rot[R-1]};
  assign w_mul_res    = r_acc ^ (r_mb[0] ? r_rot : '0);

  // Squaring in GF(2)[x]/(x^R-1) is a fixed bit permutation i -> 2i mod R.
  always_comb begin
    w_sq = '0;
    for (int i = 0; i < R; i++) begin
      w_sq[(2 * i) % R] = r_s[i];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= S_IDLE;
      r_h0        <= '0;
      r_h1        <= '0;
      r_a         <= '0;
      r_s         <= '0;
      r_rot       <= '0;
      r_mb        <= '0;
      r_acc       <= '0;
      r_w         <= '0;
      r_sel       <= 1'b0;
      r_seed      <= 1'b0;
      r_cnt       <= '0;
      r_iter      <= '0;
      r_rng_start <= 2'b00;
      r_h0_out    <= 1'b0;
      r_h1_out    <= 1'b0;
      r_f_out     <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rng_start <= 2'b00;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_h0    <= '0;
            r_h1    <= '0;
            r_w     <= '0;
            r_sel   <= 1'b0;
            r_seed  <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          r_rng_start <= r_seed ? 2'b10 : 2'b01;
          r_seed      <= 1'b0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.rng_valid) begin
            r_state <= S_REQ;
            if (w_accept) begin
              if (r_sel) r_h1 <= r_h1 | w_onehot;
              else       r_h0 <= r_h0 | w_onehot;
              if (w_full) begin
                r_w <= '0;
                if (!r_sel) begin
                  r_sel <= 1'b1;
                end else begin
                  r_a     <= ONE;
                  r_s     <= r_h0;
                  r_iter  <= '0;
                  r_state <= S_SQ;
                end
              end else begin
                r_w <= r_w + 1'b1;
              end
            end
          end
        end
        S_SQ: begin
          r_s     <= w_sq;
          r_rot   <= w_sq;
          r_mb    <= r_a;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= S_INV;
        end
        S_INV: begin
          r_acc <= w_mul_res;
          r_rot <= w_rot_nx;
          r_mb  <= r_mb >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LR'(R - 1)) begin
            r_cnt <= '0;
            if (r_iter == LR'(R - 3)) begin
              r_rot   <= r_h1;
              r_mb    <= w_mul_res;
              r_acc   <= '0;
              r_state <= S_MUL;
            end else begin
              r_a     <= w_mul_res;
              r_iter  <= r_iter + 1'b1;
              r_state <= S_SQ;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_res;
          r_rot <= w_rot_nx;
          r_mb  <= r_mb >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LR'(R - 1)) begin
            // Multiplier registers are reused as the three output shift registers.
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_h0_out    <= r_h0[0];
            r_h1_out    <= r_h1[0];
            r_f_out     <= w_mul_res[0];
            r_rot       <= r_h0 >> 1;
            r_mb        <= r_h1 >> 1;
            r_acc       <= w_mul_res >> 1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (r_cnt == LR'(R - 1)) begin
            r_out_valid <= 1'b0;
            r_h0_out    <= 1'b0;
            r_h1_out    <= 1'b0;
            r_f_out     <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_h0_out <= r_rot[0];
            r_h1_out <= r_mb[0];
            r_f_out  <= r_acc[0];
            r_rot    <= r_rot >> 1;
            r_mb     <= r_mb >> 1;
            r_acc    <= r_acc >> 1;
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rng_start = r_rng_start;
  assign bus.h0_out    = r_h0_out;
  assign bus.h1_out    = r_h1_out;
  assign bus.f_out     = r_f_out;
  assign bus.out_valid = r_out_valid;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_bike_2_keygen_top.sv
// tb/tb_bike_2_keygen_top.sv - directed bench for bike_2_keygen_top (R=101 and R=11 instances)
module tb_bike_2_keygen_top;
  logic clk;
  logic rst_b;

  bike_2_keygen_top_if bus_b ();
  bike_2_keygen_top_if bus_s ();

  bike_2_keygen_top #(.R(101), .D(15), .LR(7)) u_big (
    .clk(clk), .rst_b(rst_b), .bus(bus_b.slave)
  );
  bike_2_keygen_top #(.R(11), .D(3), .LR(4)) u_small (
    .clk(clk), .rst_b(rst_b), .bus(bus_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // PRNG stand-ins: LCG or table for the big core, position counter for the small one.
  logic        use_tbl;
  logic [63:0] tbl_b [64];
  logic [63:0] lcg;
  logic [63:0] word_b, word_s;
  logic        pend_b = 1'b0, pend_s = 1'b0;
  logic        req_b, req_s;
  int          idx_b = 0, idx_s = 0;
  int          n10_b = 0, n01_b = 0, nbad_b = 0, n10_s = 0, n01_s = 0;

  always @(negedge clk) begin
    bus_b.rng_valid = 1'b0;
    if (pend_b) begin
      bus_b.rng_valid = 1'b1;
      bus_b.rng_in    = word_b;
      pend_b          = 1'b0;
    end
    req_b = 1'b0;
    if (bus_b.rng_start == 2'b10) begin
      n10_b++; lcg = 64'd1234; idx_b = 0; req_b = 1'b1;
    end else if (bus_b.rng_start == 2'b01) begin
      n01_b++; req_b = 1'b1;
    end else if (bus_b.rng_start == 2'b11) begin
      nbad_b++;
    end
    if (req_b) begin
      if (use_tbl) begin
        word_b = (idx_b < 64) ? tbl_b[idx_b] : 64'd0;
        idx_b++;
      end else begin
        lcg    = lcg * 64'd6364136223846793005 + 64'd1442695040888963407;
        word_b = lcg ^ (lcg >> 29);
      end
      pend_b = 1'b1;
    end
  end

  always @(negedge clk) begin
    bus_s.rng_valid = 1'b0;
    if (pend_s) begin
      bus_s.rng_valid = 1'b1;
      bus_s.rng_in    = word_s;
      pend_s          = 1'b0;
    end
    req_s = 1'b0;
    if (bus_s.rng_start == 2'b10) begin
      n10_s++; idx_s = 0; req_s = 1'b1;
    end else if (bus_s.rng_start == 2'b01) begin
      n01_s++; req_s = 1'b1;
    end
    if (req_s) begin
      word_s = 64'hC0FF_EE00_0000_0000 | 64'(idx_s);
      idx_s++;
      pend_s = 1'b1;
    end
  end

  // Output capture: streams shift in LSB first; nonzero outputs outside out_valid are counted.
  logic [100:0] cap_h0, cap_h1, cap_f;
  logic [10:0]  cap_h0_s, cap_h1_s, cap_f_s;
  int nvalid_b = 0, ndone_b = 0, nz_b = 0, nvalid_s = 0, ndone_s = 0;

  always @(negedge clk) begin
    if (bus_b.out_valid) begin
      cap_h0 = {bus_b.h0_out, cap_h0[100:1]};
      cap_h1 = {bus_b.h1_out, cap_h1[100:1]};
      cap_f  = {bus_b.f_out,  cap_f[100:1]};
      nvalid_b++;
    end else if (bus_b.h0_out | bus_b.h1_out | bus_b.f_out) begin
      nz_b++;
    end
    if (bus_b.done) ndone_b++;
    if (bus_s.out_valid) begin
      cap_h0_s = {bus_s.h0_out, cap_h0_s[10:1]};
      cap_h1_s = {bus_s.h1_out, cap_h1_s[10:1]};
      cap_f_s  = {bus_s.f_out,  cap_f_s[10:1]};
      nvalid_s++;
    end
    if (bus_s.done) ndone_s++;
  end

  function automatic logic [100:0] cmul(input logic [100:0] a, input logic [100:0] b);
    logic [100:0] acc, r;
    acc = '0;
    r   = a;
    for (int j = 0; j < 101; j++) begin
      if (b[j]) acc ^= r;
      r = {r[99:0], r[100]};
    end
    return acc;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int b10, b01, bbad, bvalid, bdone, bnz;

  task automatic mark_big();
    b10 = n10_b; b01 = n01_b; bbad = nbad_b; bvalid = nvalid_b; bdone = ndone_b; bnz = nz_b;
  endtask

  task automatic pulse_start_big();
    @(negedge clk); bus_b.start = 1'b1;
    @(negedge clk);
    @(negedge clk); bus_b.start = 1'b0;
  endtask

  task automatic wait_big_done(input string tag, input int budget);
    int t;
    t = 0;
    while (ndone_b == bdone && t < budget) begin
      @(negedge clk); t++;
    end
    check(tag, 128'(ndone_b != bdone), 128'(1));
    repeat (3) @(negedge clk);
  endtask

  task automatic check_key(input string tag);
    check({tag, "_valid_cycles"}, 128'(nvalid_b - bvalid), 128'(101));
    check({tag, "_done_count"}, 128'(ndone_b - bdone), 128'(1));
    check({tag, "_wt_h0"}, 128'($countones(cap_h0)), 128'(15));
    check({tag, "_wt_h1"}, 128'($countones(cap_h1)), 128'(15));
    check({tag, "_f_times_h0"}, 128'(cmul(cap_f, cap_h0)), 128'(cap_h1));
    check({tag, "_idle_zero"}, 128'(nz_b - bnz), 128'(0));
    check({tag, "_seed_pulses"}, 128'(n10_b - b10), 128'(1));
    check({tag, "_bad_cmd"}, 128'(nbad_b - bbad), 128'(0));
  endtask

  logic [100:0] exp_h0, exp_h1;
  int t;

  initial begin
    rst_b       = 1'b0;
    bus_b.start = 1'b0;
    bus_s.start = 1'b0;
    use_tbl     = 1'b0;
    for (int i = 0; i < 64; i++) tbl_b[i] = 64'd0;

    // Reset state
    #100;
    check("rst_rng_start", 128'(bus_b.rng_start), 128'(0));
    check("rst_outputs", 128'({bus_b.h0_out, bus_b.h1_out, bus_b.f_out, bus_b.done}), 128'(0));
    check("rst_out_valid", 128'(bus_b.out_valid), 128'(0));
    check("rst_small_rng_start", 128'(bus_s.rng_start), 128'(0));
    rst_b = 1'b1;
    #20;
    check("idle_rng_start", 128'(bus_b.rng_start), 128'(0));
    check("idle_out_valid", 128'(bus_b.out_valid), 128'(0));

    // Nominal LCG-driven keygen
    mark_big();
    pulse_start_big();
    wait_big_done("nom_done_seen", 14000);
    check_key("nom");
    check("nom_min_requests", 128'((n01_b - b01) >= 29), 128'(1));

    // Rejection sampling with a start pulse landing during inversion
    use_tbl = 1'b1;
    tbl_b[0] = 64'hDEAD_BEEF_0000_007F;
    tbl_b[1] = 64'hDEAD_BEEF_0000_0065;
    tbl_b[2] = 64'hDEAD_BEEF_0000_0005;
    tbl_b[3] = 64'hDEAD_BEEF_0000_0005;
    tbl_b[4] = 64'hDEAD_BEEF_0000_0006;
    for (int i = 5; i < 33; i++) tbl_b[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i + 2);
    exp_h0 = '0;
    exp_h1 = '0;
    for (int i = 5; i < 20; i++) exp_h0[i] = 1'b1;
    for (int i = 20; i < 35; i++) exp_h1[i] = 1'b1;
    mark_big();
    pulse_start_big();
    t = 0;
    while ((n01_b - b01) < 32 && t < 2000) begin
      @(negedge clk); t++;
    end
    check("rej_requests_reached", 128'((n01_b - b01) >= 32), 128'(1));
    repeat (300) @(negedge clk);
    pulse_start_big();
    wait_big_done("rej_done_seen", 14000);
    check_key("rej");
    check("rej_h0_bits", 128'(cap_h0), 128'(exp_h0));
    check("rej_h1_bits", 128'(cap_h1), 128'(exp_h1));
    check("rej_requests", 128'(n01_b - b01), 128'(32));
    repeat (200) @(negedge clk);
    check("busy_single_done", 128'(ndone_b - bdone), 128'(1));
    check("busy_no_restart", 128'(n10_b - b10), 128'(1));

    // Small ring: h0 = 1+x+x^2, h1 = x^3+x^4+x^5, so f = x^3
    @(negedge clk); bus_s.start = 1'b1;
    @(negedge clk); bus_s.start = 1'b0;
    t = 0;
    while (ndone_s == 0 && t < 2000) begin
      @(negedge clk); t++;
    end
    repeat (3) @(negedge clk);
    check("small_done_count", 128'(ndone_s), 128'(1));
    check("small_valid_cycles", 128'(nvalid_s), 128'(11));
    check("small_h0", 128'(cap_h0_s), 128'(11'h007));
    check("small_h1", 128'(cap_h1_s), 128'(11'h038));
    check("small_f", 128'(cap_f_s), 128'(11'h008));
    check("small_requests", 128'({n10_s[7:0], n01_s[7:0]}), 128'(16'h0105));

    // Reset while drawing h1, then a clean key afterwards
    for (int i = 0; i < 64; i++) tbl_b[i] = 64'h1234_0000_0000_0000 | 64'(i);
    mark_big();
    pulse_start_big();
    t = 0;
    while ((n01_b - b01) < 17 && t < 2000) begin
      @(negedge clk); t++;
    end
    check("mid_reached_h1", 128'((n01_b - b01) >= 17), 128'(1));
    rst_b = 1'b0;
    #1;
    check("mid_rst_rng_start", 128'(bus_b.rng_start), 128'(0));
    check("mid_rst_outputs", 128'({bus_b.out_valid, bus_b.h0_out, bus_b.h1_out, bus_b.f_out, bus_b.done}), 128'(0));
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_no_partial", 128'(nvalid_b - bvalid), 128'(0));
    check("mid_no_done", 128'(ndone_b - bdone), 128'(0));
    check("mid_idle_after", 128'(bus_b.rng_start), 128'(0));
    use_tbl = 1'b0;
    mark_big();
    pulse_start_big();
    wait_big_done("restart_done_seen", 14000);
    check_key("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
